nodf_module_intf: RTL and testbench
===================================

NODF_MODULE_INTF -- requirements
Module: nodf_module_intf

Interface
REQ-001 Parameter CNT_W, default 32: width of the transaction, latency and stall counters.
REQ-002 Parameter MAX_OUT, default 15: maximum outstanding transactions tracked; outstanding-count width is clog2(MAX_OUT+1).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ap_start  in  1  DUT start request.
REQ-006 ap_ready  in  1  DUT has accepted its inputs.
REQ-007 ap_done  in  1  DUT result valid.
REQ-008 ap_continue  in  1  downstream accepts the result; tie to 1 for no backpressure.
REQ-009 finish  in  1  end of simulation or test; freezes the monitor.
REQ-010 state  out  2  monitor state: IDLE=0, ACTIVE=1, FINISHED=2.
REQ-011 start_cnt  out  CNT_W  number of accepted starts.
REQ-012 done_cnt  out  CNT_W  number of accepted completions.
REQ-013 outstanding  out  clog2(MAX_OUT+1)  number of transactions started but not yet completed.
REQ-014 last_lat / min_lat / max_lat  out  CNT_W each  latency statistics, in cycles.
REQ-015 sat  out  1  sticky flag: some counter has saturated.
REQ-016 proto_err  out  1  sticky flag: a protocol violation was detected.

Function
REQ-017 Start event = ap_start & ap_ready in a cycle. Done event = ap_done & ap_continue in a cycle.
REQ-018 When not FINISHED, start_cnt increments by 1 on each start event and done_cnt increments by 1 on each done event, both registered with one-cycle latency.
REQ-019 outstanding changes as follows on a simultaneous start and done: +1 on start only, -1 on done only, unchanged on both.
REQ-020 A cycle counter cur_lat runs whenever outstanding>0, or when a start event occurs while outstanding is 0.
REQ-021 On a done event:
- last_lat becomes cur_lat+1.
- min_lat and max_lat are updated from last_lat.
- cur_lat reloads to 0 if transactions remain outstanding; otherwise it stops.
REQ-022 A start and done in the same cycle with outstanding=1 records the completed latency and immediately begins a new measurement at 0.
REQ-023 A done event with outstanding=0 sets proto_err and is otherwise ignored: no counts change.
REQ-024 A start event with outstanding=MAX_OUT sets proto_err; start_cnt still increments and outstanding holds at MAX_OUT.
REQ-025 Every counter saturates at all-ones and holds that value; any saturation sets sat.
REQ-026 State transitions:
- IDLE goes to ACTIVE on a start event.
- ACTIVE goes to IDLE when outstanding reaches 0.
- Any state goes to FINISHED on finish=1, which takes priority over all events in that cycle.
- FINISHED is left only by reset.
REQ-027 In FINISHED, all outputs are frozen.
REQ-028 min_lat reads all-ones until the first completion.

Reset
REQ-029 Reset assertion asynchronously clears all registers. Resulting values: state=IDLE; every counter, last_lat and max_lat=0; min_lat=all-ones; sat=0; proto_err=0.
REQ-030 Reset takes effect mid-transaction without completing the transaction. Events are sampled again from the first rising edge after reset deasserts.

Configuration
REQ-031 With NODF_MODULE_INTF_STALL_EN defined, the block has two extra outputs:
- stall_cnt (CNT_W): counts cycles in which ap_done=1 and ap_continue=0.
- stalled (1): combinational output equal to ap_done & ~ap_continue.
REQ-032 Without NODF_MODULE_INTF_STALL_EN, those ports and their logic do not exist.

Structure
REQ-033 Package nodf_module_pkg holds the state enum (IDLE, ACTIVE, FINISHED) and the default constants CNT_W_DEF=32 and MAX_OUT_DEF=15.
REQ-034 One sub-module, nodf_sat_counter, is a saturating incrementer with clear and load. It is instantiated for start_cnt, done_cnt, cur_lat and stall_cnt.

Verification
REQ-035 Single transaction, no backpressure: ap_start&ap_ready at cycle 0, then ap_done&ap_continue at cycle 5 -> start_cnt=1, done_cnt=1, last_lat=6, min_lat=6, max_lat=6, state ACTIVE then IDLE.
REQ-036 Back-to-back with overlap: starts at cycles 0 and 3, dones at 4 and 9 -> outstanding sequence 1,2,1,0; last_lat=5; min_lat=5; max_lat=5.
REQ-037 Spurious ap_done&ap_continue while IDLE -> proto_err=1, done_cnt=0, outstanding=0.
REQ-038 finish=1 during ACTIVE with outstanding=1, followed by 3 further done events -> state=FINISHED, done_cnt unchanged, all outputs frozen until reset.
REQ-039 CNT_W=4: 17 start/done pairs -> start_cnt=15, sat=1.
REQ-040 With NODF_MODULE_INTF_STALL_EN: ap_done=1 with ap_continue=0 for 4 cycles, then ap_continue=1 -> stall_cnt=4, done_cnt=1. Separately, reset asserted mid-transaction -> all outputs at reset values immediately.

Source files
------------

// File: rtl/nodf_module_pkg.sv
// Shared types and defaults for the nodf_module_intf transaction monitor.
// Optional stall counting is enabled with NODF_MODULE_INTF_STALL_EN.
package nodf_module_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    FINISHED = 2'd2
  } mon_state_t;

  localparam int CNT_W_DEF   = 32;
  localparam int MAX_OUT_DEF = 15;

endpackage

// File: rtl/nodf_module_intf_sat_counter.sv
// nodf_sat_counter: saturating incrementer with clear and load.
// hit flags an increment that reaches or sits at all-ones.
module nodf_sat_counter
  import nodf_module_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         hit
);

  localparam logic [W-1:0] MAXV = '1;

  logic bump;

  assign bump = inc & ~clr & ~ld;
  assign hit  = bump & (q >= MAXV - W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (bump && q != MAXV) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/nodf_module_intf.sv
// nodf_module_intf: ap_* handshake monitor with counts and latency stats.
// Define NODF_MODULE_INTF_STALL_EN to add stall_cnt / stalled.
module nodf_module_intf
  import nodf_module_pkg::*;
#(
  parameter int  CNT_W   = CNT_W_DEF,
  parameter int  MAX_OUT = MAX_OUT_DEF,
  localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [OUT_W-1:0] outstanding,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic             sat,
  output logic             proto_err
`ifdef NODF_MODULE_INTF_STALL_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stalled
`endif
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

  mon_state_t       st_q;
  mon_state_t       st_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic [CNT_W-1:0] cur_lat;
  logic [CNT_W-1:0] new_lat;
  logic             live;
  logic             start_ev;
  logic             done_ev;
  logic             done_ok;
  logic             out_zero;
  logic             out_full;
  logic             lat_clr;
  logic             lat_ld;
  logic             lat_inc;
  logic             hit_s;
  logic             hit_d;
  logic             hit_l;
  logic             hit_x;

  // finish wins over any event in the same cycle
  assign live     = (st_q != FINISHED) & ~finish;
  assign start_ev = live & ap_start & ap_ready;
  assign done_ev  = live & ap_done & ap_continue;
  assign out_zero = (out_q == '0);
  assign out_full = (out_q == OUT_MAX);
  assign done_ok  = done_ev & ~out_zero;

  always_comb begin
    out_d = out_q;
    unique case (1'b1)
      start_ev & ~done_ok & ~out_full:
        out_d = out_q + OUT_W'(1);
      done_ok & ~start_ev:
        out_d = out_q - OUT_W'(1);
      default: ;
    endcase
  end

  // cur_lat counts the start cycle itself, hence the load of 1
  assign lat_clr = done_ok & (out_d != '0);
  assign lat_ld  = start_ev & out_zero;
  assign lat_inc = live & ~out_zero & ~done_ok;

  assign new_lat = (cur_lat == ONES) ? ONES
                 : cur_lat + CNT_W'(1);

  nodf_sat_counter #(.W(CNT_W)) u_start (
    .clock  (clock),
    .reset  (reset),
    .clr    (1'b0),
    .ld     (1'b0),
    .ld_val ({CNT_W{1'b0}}),
    .inc    (start_ev),
    .q      (start_cnt),
    .hit    (hit_s)
  );

  nodf_sat_counter #(.W(CNT_W)) u_done (
    .clock  (clock),
    .reset  (reset),
    .clr    (1'b0),
    .ld     (1'b0),
    .ld_val ({CNT_W{1'b0}}),
    .inc    (done_ok),
    .q      (done_cnt),
    .hit    (hit_d)
  );

  nodf_sat_counter #(.W(CNT_W)) u_lat (
    .clock  (clock),
    .reset  (reset),
    .clr    (lat_clr),
    .ld     (lat_ld),
    .ld_val (CNT_W'(1)),
    .inc    (lat_inc),
    .q      (cur_lat),
    .hit    (hit_l)
  );

`ifdef NODF_MODULE_INTF_STALL_EN
  assign stalled = ap_done & ~ap_continue;

  nodf_sat_counter #(.W(CNT_W)) u_stall (
    .clock  (clock),
    .reset  (reset),
    .clr    (1'b0),
    .ld     (1'b0),
    .ld_val ({CNT_W{1'b0}}),
    .inc    (live & stalled),
    .q      (stall_cnt),
    .hit    (hit_x)
  );
`else
  assign hit_x = 1'b0;
`endif

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:     if (start_ev) st_d = ACTIVE;
      ACTIVE:   if (out_d == '0) st_d = IDLE;
      FINISHED: st_d = FINISHED;
      default:  st_d = IDLE;
    endcase
    if (finish) st_d = FINISHED;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q      <= IDLE;
      out_q     <= '0;
      last_lat  <= '0;
      min_lat   <= ONES;
      max_lat   <= '0;
      sat       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      st_q  <= st_d;
      out_q <= out_d;
      if (done_ok) begin
        last_lat <= new_lat;
        if (new_lat < min_lat) min_lat <= new_lat;
        if (new_lat > max_lat) max_lat <= new_lat;
      end
      if (hit_s | hit_d | hit_l | hit_x) sat <= 1'b1;
      if ((done_ev & out_zero) | (start_ev & out_full))
        proto_err <= 1'b1;
    end
  end

  assign state       = st_q;
  assign outstanding = out_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf (default and CNT_W=4 builds).
// Stall checks are added when NODF_MODULE_INTF_STALL_EN is defined.
module tb_nodf_module_intf;
  import nodf_module_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_continue = 1'b0;
  logic        finish = 1'b0;

  logic [1:0]  state;
  logic [31:0] start_cnt;
  logic [31:0] done_cnt;
  logic [3:0]  outstanding;
  logic [31:0] last_lat;
  logic [31:0] min_lat;
  logic [31:0] max_lat;
  logic        sat;
  logic        proto_err;

  logic [1:0]  state4;
  logic [3:0]  start_cnt4;
  logic [3:0]  done_cnt4;
  logic [3:0]  outstanding4;
  logic [3:0]  last_lat4;
  logic [3:0]  min_lat4;
  logic [3:0]  max_lat4;
  logic        sat4;
  logic        proto_err4;

`ifdef NODF_MODULE_INTF_STALL_EN
  logic [31:0] stall_cnt;
  logic        stalled;
  logic [3:0]  stall_cnt4;
  logic        stalled4;
`endif

  int n_chk = 0;
  int n_fail = 0;

  nodf_module_intf dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .finish      (finish),
    .state       (state),
    .start_cnt   (start_cnt),
    .done_cnt    (done_cnt),
    .outstanding (outstanding),
    .last_lat    (last_lat),
    .min_lat     (min_lat),
    .max_lat     (max_lat),
    .sat         (sat),
    .proto_err   (proto_err)
`ifdef NODF_MODULE_INTF_STALL_EN
    ,
    .stall_cnt   (stall_cnt),
    .stalled     (stalled)
`endif
  );

  nodf_module_intf #(.CNT_W(4)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .finish      (finish),
    .state       (state4),
    .start_cnt   (start_cnt4),
    .done_cnt    (done_cnt4),
    .outstanding (outstanding4),
    .last_lat    (last_lat4),
    .min_lat     (min_lat4),
    .max_lat     (max_lat4),
    .sat         (sat4),
    .proto_err   (proto_err4)
`ifdef NODF_MODULE_INTF_STALL_EN
    ,
    .stall_cnt   (stall_cnt4),
    .stalled     (stalled4)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic d);
    ap_start    = s;
    ap_ready    = s;
    ap_done     = d;
    ap_continue = d;
    @(posedge clock);
    #1;
    ap_start    = 1'b0;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    ap_continue = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_start", start_cnt, 32'd0);
    check("rst_done", done_cnt, 32'd0);
    check("rst_out", 32'(outstanding), 32'd0);
    check("rst_last", last_lat, 32'd0);
    check("rst_min", min_lat, 32'hFFFF_FFFF);
    check("rst_max", max_lat, 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    check("rst_min4", 32'(min_lat4), 32'hF);

    // single transaction, start cycle 0, done cycle 5
    step(1'b1, 1'b0);
    check("t1_state_act", 32'(state), 32'd1);
    check("t1_start", start_cnt, 32'd1);
    check("t1_out", 32'(outstanding), 32'd1);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t1_done", done_cnt, 32'd1);
    check("t1_last", last_lat, 32'd6);
    check("t1_min", min_lat, 32'd6);
    check("t1_max", max_lat, 32'd6);
    check("t1_state_idle", 32'(state), 32'd0);

    // overlap: starts 0,3 dones 4,9
    do_reset();
    step(1'b1, 1'b0);
    check("t2_out_c0", 32'(outstanding), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("t2_out_c3", 32'(outstanding), 32'd2);
    step(1'b0, 1'b1);
    check("t2_out_c4", 32'(outstanding), 32'd1);
    check("t2_last_c4", last_lat, 32'd5);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t2_out_c9", 32'(outstanding), 32'd0);
    check("t2_last", last_lat, 32'd5);
    check("t2_min", min_lat, 32'd5);
    check("t2_max", max_lat, 32'd5);

    // shorter follow-up moves min only
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t2b_last", last_lat, 32'd3);
    check("t2b_min", min_lat, 32'd3);
    check("t2b_max", max_lat, 32'd5);

    // spurious done while idle
    do_reset();
    step(1'b0, 1'b1);
    check("t3_perr", 32'(proto_err), 32'd1);
    check("t3_done", done_cnt, 32'd0);
    check("t3_out", 32'(outstanding), 32'd0);
    check("t3_last", last_lat, 32'd0);

    // start and done together with one outstanding
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("t4_last_a", last_lat, 32'd3);
    check("t4_out", 32'(outstanding), 32'd1);
    check("t4_start", start_cnt, 32'd2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t4_last_b", last_lat, 32'd2);
    check("t4_min", min_lat, 32'd2);
    check("t4_max", max_lat, 32'd3);
    check("t4_state", 32'(state), 32'd0);
    check("t4_perr", 32'(proto_err), 32'd0);

    // outstanding limit
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    check("t5_out_full", 32'(outstanding), 32'd15);
    check("t5_perr0", 32'(proto_err), 32'd0);
    step(1'b1, 1'b0);
    check("t5_out_hold", 32'(outstanding), 32'd15);
    check("t5_start", start_cnt, 32'd16);
    check("t5_perr1", 32'(proto_err), 32'd1);

    // finish freezes everything, even with a done in that cycle
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    finish = 1'b1;
    step(1'b0, 1'b1);
    finish = 1'b0;
    check("t6_state", 32'(state), 32'd2);
    check("t6_done0", done_cnt, 32'd0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("t6_state_hold", 32'(state), 32'd2);
    check("t6_done", done_cnt, 32'd0);
    check("t6_start", start_cnt, 32'd1);
    check("t6_out", 32'(outstanding), 32'd1);
    check("t6_last", last_lat, 32'd0);
    check("t6_min", min_lat, 32'hFFFF_FFFF);
    check("t6_perr", 32'(proto_err), 32'd0);

    // 4-bit counters saturate
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      if (i == 13) check("t7_sat4_pre", 32'(sat4), 32'd0);
    end
    check("t7_start4", 32'(start_cnt4), 32'd15);
    check("t7_sat4", 32'(sat4), 32'd1);
    check("t7_start32", start_cnt, 32'd17);
    check("t7_done32", done_cnt, 32'd17);
    check("t7_sat32", 32'(sat), 32'd0);
    check("t7_last4", 32'(last_lat4), 32'd2);

    // asynchronous reset mid-transaction
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("t8_start_pre", start_cnt, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t8_state", 32'(state), 32'd0);
    check("t8_start", start_cnt, 32'd0);
    check("t8_out", 32'(outstanding), 32'd0);
    check("t8_min", min_lat, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    reset = 1'b1;

`ifdef NODF_MODULE_INTF_STALL_EN
    do_reset();
    step(1'b1, 1'b0);
    ap_done     = 1'b1;
    ap_continue = 1'b0;
    #1;
    check("t9_stalled", 32'(stalled), 32'd1);
    repeat (4) @(posedge clock);
    #1;
    step(1'b0, 1'b1);
    check("t9_stall_cnt", stall_cnt, 32'd4);
    check("t9_done", done_cnt, 32'd1);
    check("t9_stalled_off", 32'(stalled), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
